spare_alu_arbiter: RTL

- Shares one spare ALU instance between two requesters, lane 0 and lane 1 (e.g. a main-pipe offload lane and a self-check lane).
- Accepts operations over per-lane valid/ready handshakes and arbitrates them round-robin.
- Drives the shared ALU through a registered issue stage and returns tagged results on a single response channel with backpressure.
- Keeps a saturating per-lane grant counter for performance and coverage monitoring.

---
 rtl/spare_alu_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/spare_alu_arbiter.sv
// rtl/spare_alu_arbiter.sv - round-robin arbiter sharing one spare ALU between two lanes
module spare_alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               spare_en,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    input  logic [5:0]         req_ctrl,
    output logic [WIDTH-1:0]   alu_srca,
    output logic [WIDTH-1:0]   alu_srcb,
    output logic [2:0]         alu_control,
    input  logic [WIDTH-1:0]   alu_result,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_data,
    output logic [CNT_W-1:0]   grant_cnt0,
    output logic [CNT_W-1:0]   grant_cnt1
);

    logic             last_grant_q, last_grant_d;
    logic             iss_valid_q, iss_valid_d;
    logic             iss_id_q, iss_id_d;
    logic [WIDTH-1:0] srca_q, srca_d;
    logic [WIDTH-1:0] srcb_q, srcb_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic       rsp_adv;
    logic       iss_adv;
    logic       eligible;
    logic [1:0] grant;

    // Grant is combinational on req_valid; rst_n gating keeps req_ready low during reset.
    always_comb begin
        rsp_adv  = !rsp_valid_q || rsp_ready;
        iss_adv  = !iss_valid_q || rsp_adv;
        eligible = rst_n && spare_en && iss_adv;
        grant    = 2'b00;
        if (eligible) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        iss_valid_d  = iss_valid_q;
        iss_id_d     = iss_id_q;
        srca_d       = srca_q;
        srcb_d       = srcb_q;
        ctrl_d       = ctrl_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;

        if (grant != 2'b00) begin
            iss_valid_d  = 1'b1;
            iss_id_d     = grant[1];
            last_grant_d = grant[1];
            srca_d       = grant[1] ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
            srcb_d       = grant[1] ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
            ctrl_d       = grant[1] ? req_ctrl[5:3] : req_ctrl[2:0];
        end else if (iss_adv) begin
            iss_valid_d = 1'b0;
        end

        if (grant[0] && (cnt0_q != {CNT_W{1'b1}})) begin
            cnt0_d = cnt0_q + CNT_W'(1);
        end
        if (grant[1] && (cnt1_q != {CNT_W{1'b1}})) begin
            cnt1_d = cnt1_q + CNT_W'(1);
        end

        if (rsp_adv) begin
            rsp_valid_d = iss_valid_q;
            if (iss_valid_q) begin
                rsp_data_d = alu_result;
                rsp_id_d   = iss_id_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            iss_valid_q  <= 1'b0;
            iss_id_q     <= 1'b0;
            srca_q       <= '0;
            srcb_q       <= '0;
            ctrl_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            iss_valid_q  <= iss_valid_d;
            iss_id_q     <= iss_id_d;
            srca_q       <= srca_d;
            srcb_q       <= srcb_d;
            ctrl_q       <= ctrl_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign req_ready   = grant;
    assign alu_srca    = srca_q;
    assign alu_srcb    = srcb_q;
    assign alu_control = ctrl_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign grant_cnt0  = cnt0_q;
    assign grant_cnt1  = cnt1_q;

endmodule
